// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exception_sequencer
// Description : Multicycle exception sequencer for the MIPS datapath. On an
//               invalid-opcode, overflow or divide-by-zero event it stalls the
//               main control unit, saves PC-4 into EPC, reads the handler
//               address byte from a fixed vector in memory and loads it into
//               the PC before handing control back.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_sequencer #(
    parameter int unsigned VEC_OPCODE = 253,
    parameter int unsigned VEC_OVF    = 254,
    parameter int unsigned VEC_DIV0   = 255,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic        pc_w,
    output logic [31:0] pc_data,
    output logic [31:0] epc,
    output logic [1:0]  cause
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SAVE  = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_LOAD  = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    // Counter is 3 bits wide because the memory latency is limited to 1..7.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [31:0] vec_addr;
    logic        any_exc;
    logic [1:0]  new_cause;

    // Only the handler byte is used; the upper read data is intentionally dropped.
    logic        unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[31:8];

    assign any_exc = exc_opcode | exc_ovf | exc_div0;

    // Priority encode simultaneous events: opcode beats overflow beats div0.
    always_comb begin
        new_cause = CAUSE_NONE;
        if (exc_opcode) begin
            new_cause = CAUSE_OPCODE;
        end else if (exc_ovf) begin
            new_cause = CAUSE_OVF;
        end else if (exc_div0) begin
            new_cause = CAUSE_DIV0;
        end
    end

    // Handler vector address chosen from the latched cause only.
    always_comb begin
        vec_addr = VEC_DIV0;
        case (cause)
            CAUSE_OPCODE: vec_addr = VEC_OPCODE;
            CAUSE_OVF:    vec_addr = VEC_OVF;
            default:      vec_addr = VEC_DIV0;
        endcase
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            busy     <= 1'b0;
            mem_sel  <= 1'b0;
            mem_addr <= 32'd0;
            pc_w     <= 1'b0;
            pc_data  <= 32'd0;
            epc      <= 32'd0;
            cause    <= CAUSE_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    // Events are only looked at here; anything arriving while
                    // busy is dropped rather than queued.
                    if (any_exc) begin
                        cause <= new_cause;
                        busy  <= 1'b1;
                        state <= S_SAVE;
                    end
                end

                S_SAVE: begin
                    // Wraps modulo 2^32, so PC 0 yields FFFF_FFFC.
                    epc      <= pc_in - 32'd4;
                    mem_sel  <= 1'b1;
                    mem_addr <= vec_addr;
                    state    <= S_FETCH;
                end

                S_FETCH: begin
                    wait_cnt <= LAT_LOAD;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    // Leaving on the edge where the count reaches zero; the
                    // handler byte is captured on that same edge.
                    if (wait_cnt <= 3'd1) begin
                        wait_cnt <= 3'd0;
                        pc_w     <= 1'b1;
                        pc_data  <= {24'd0, mem_rdata[7:0]};
                        state    <= S_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                S_LOAD: begin
                    // PC takes pc_data on this edge; release the datapath.
                    pc_w     <= 1'b0;
                    pc_data  <= 32'd0;
                    mem_sel  <= 1'b0;
                    mem_addr <= 32'd0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    wait_cnt <= 3'd0;
                    busy     <= 1'b0;
                    mem_sel  <= 1'b0;
                    mem_addr <= 32'd0;
                    pc_w     <= 1'b0;
                    pc_data  <= 32'd0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exception_sequencer
// Description : Directed self-checking bench for exception_sequencer, with a
//               default-latency instance and a MEM_LAT=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_sequencer;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        exc_opcode, exc_ovf, exc_div0;
    logic [31:0] pc_in;

    logic        busy1, mem_sel1, pc_w1;
    logic [31:0] mem_addr1, pc_data1, epc1, mem_rdata1;
    logic [1:0]  cause1;
    logic        busy3, mem_sel3, pc_w3;
    logic [31:0] mem_addr3, pc_data3, epc3, mem_rdata3;
    logic [1:0]  cause3;

    logic        busy, mem_sel, pc_w;
    logic [31:0] mem_addr, pc_data, epc;
    logic [1:0]  cause;

    int errors = 0;
    int checks = 0;

    // Vector memory: upper bytes are junk so truncation is visible.
    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'd253: memval = 32'hFFFF_FF21;
            32'd254: memval = 32'hAAAA_AA5C;
            32'd255: memval = 32'h1234_5690;
            default: memval = 32'hDEAD_BE00;
        endcase
    endfunction

    assign mem_rdata1 = memval(mem_addr1);
    assign mem_rdata3 = memval(mem_addr3);

    exception_sequencer dut1 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode & ~sel), .exc_ovf(exc_ovf & ~sel), .exc_div0(exc_div0 & ~sel),
        .pc_in(pc_in), .mem_rdata(mem_rdata1),
        .busy(busy1), .mem_sel(mem_sel1), .mem_addr(mem_addr1), .pc_w(pc_w1),
        .pc_data(pc_data1), .epc(epc1), .cause(cause1)
    );

    exception_sequencer #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode & sel), .exc_ovf(exc_ovf & sel), .exc_div0(exc_div0 & sel),
        .pc_in(pc_in), .mem_rdata(mem_rdata3),
        .busy(busy3), .mem_sel(mem_sel3), .mem_addr(mem_addr3), .pc_w(pc_w3),
        .pc_data(pc_data3), .epc(epc3), .cause(cause3)
    );

    assign busy     = sel ? busy3     : busy1;
    assign mem_sel  = sel ? mem_sel3  : mem_sel1;
    assign mem_addr = sel ? mem_addr3 : mem_addr1;
    assign pc_w     = sel ? pc_w3     : pc_w1;
    assign pc_data  = sel ? pc_data3  : pc_data1;
    assign epc      = sel ? epc3      : epc1;
    assign cause    = sel ? cause3    : cause1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full exception sequence on the selected instance, cycle by cycle.
    task automatic run_seq(input string tag, input logic [2:0] ev, input logic [31:0] pc,
                           input logic [1:0] exp_cause, input logic [31:0] exp_epc,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data,
                           input int lat);
        int busy_cnt = 0;
        int sel_cnt  = 0;
        int pcw_cnt  = 0;
        @(negedge clk);
        {exc_opcode, exc_ovf, exc_div0} = ev;
        pc_in = pc;
        step();
        {exc_opcode, exc_ovf, exc_div0} = 3'b000;
        for (int c = 0; c <= lat + 5; c++) begin
            if (c == 0) begin
                check({tag, ".cause"}, 32'(cause), 32'(exp_cause));
                check({tag, ".save_sel"}, 32'(mem_sel), 32'd0);
            end
            if (c == 1) begin
                check({tag, ".epc"}, epc, exp_epc);
                check({tag, ".addr"}, mem_addr, exp_addr);
            end
            if (busy) busy_cnt++;
            if (mem_sel) sel_cnt++;
            if (pc_w) begin
                pcw_cnt++;
                check({tag, ".pcw_cycle"}, 32'(c), 32'(2 + lat));
                check({tag, ".pc_data"}, pc_data, exp_data);
                check({tag, ".load_addr"}, mem_addr, exp_addr);
            end else if (pc_data != 32'd0) begin
                check({tag, ".pc_data_idle"}, pc_data, 32'd0);
            end
            step();
        end
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(3 + lat));
        check({tag, ".sel_cycles"}, 32'(sel_cnt), 32'(2 + lat));
        check({tag, ".pcw_cycles"}, 32'(pcw_cnt), 32'd1);
        check({tag, ".cause_kept"}, 32'(cause), 32'(exp_cause));
        check({tag, ".epc_kept"}, epc, exp_epc);
        check({tag, ".idle_addr"}, mem_addr, 32'd0);
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b0;
        exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
        pc_in = 32'd0;
        #12;
        check("rst.busy", 32'(busy1), 32'd0);
        check("rst.cause", 32'(cause1), 32'd0);
        check("rst.epc", epc1, 32'd0);
        check("rst.addr", mem_addr1, 32'd0);
        check("rst.pc_w", 32'(pc_w1), 32'd0);
        check("rst3.busy", 32'(busy3), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        run_seq("ovf", 3'b010, 32'h0000_0040, 2'b10, 32'h0000_003C, 32'd254, 32'h5C, 1);
        run_seq("prio", 3'b101, 32'h0000_0100, 2'b01, 32'h0000_00FC, 32'd253, 32'h21, 1);
        run_seq("pc0", 3'b001, 32'h0000_0000, 2'b11, 32'hFFFF_FFFC, 32'd255, 32'h90, 1);

        // Events during SAVE and LOAD are dropped; one right after LOAD is taken.
        @(negedge clk);
        exc_opcode = 1'b1;
        pc_in = 32'h300;
        step();
        exc_opcode = 1'b0;
        exc_ovf = 1'b1;
        step();
        exc_ovf = 1'b0;
        check("drop.cause_save", 32'(cause1), 32'd1);
        step();
        step();
        check("drop.in_load", 32'(pc_w1), 32'd1);
        exc_ovf = 1'b1;
        step();
        exc_ovf = 1'b0;
        check("drop.after_load_busy", 32'(busy1), 32'd0);
        check("drop.after_load_cause", 32'(cause1), 32'd1);
        exc_ovf = 1'b1;
        step();
        exc_ovf = 1'b0;
        check("reentry.busy", 32'(busy1), 32'd1);
        check("reentry.cause", 32'(cause1), 32'd2);
        for (int i = 0; i < 4; i++) step();
        check("reentry.done", 32'(busy1), 32'd0);

        // Asynchronous reset while waiting on memory.
        @(negedge clk);
        exc_div0 = 1'b1;
        pc_in = 32'h500;
        step();
        exc_div0 = 1'b0;
        step();
        step();
        check("mid.in_wait", 32'(mem_sel1), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid.busy", 32'(busy1), 32'd0);
        check("mid.mem_sel", 32'(mem_sel1), 32'd0);
        check("mid.cause", 32'(cause1), 32'd0);
        check("mid.epc", epc1, 32'd0);
        check("mid.addr", mem_addr1, 32'd0);
        check("mid.pc_w", 32'(pc_w1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        run_seq("postrst", 3'b001, 32'h0000_0080, 2'b11, 32'h0000_007C, 32'd255, 32'h90, 1);

        // Longer memory latency instance.
        sel = 1'b1;
        step();
        run_seq("lat3", 3'b010, 32'h0000_1000, 2'b10, 32'h0000_0FFC, 32'd254, 32'h5C, 3);
        check("lat3.dut1_quiet", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
